// File: rtl/execute_stage_md.sv
// execute_stage_md: RV32IM/RV64IM execute stage with operand forwarding, a
// single-cycle ALU/multiplier, an iterative restoring divider and the E->M
// pipeline register. A divide holds BusyE high while it iterates.
// Optional build macro: EXEC_DIV_FASTPATH_EN resolves divides whose divisor
// magnitude is 0 or 1 in a single cycle without raising BusyE.
module execute_stage_md #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MEM_TYPE_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ValidE,
    input  logic                  FlushE,
    input  logic                  RegWriteE,
    input  logic                  ResultSrcE,
    input  logic                  MemWriteE,
    input  logic [MEM_TYPE_W-1:0] MemTypeE,
    input  logic [4:0]            ALUCtrlE,
    input  logic                  ALUSrcE,
    input  logic [XLEN-1:0]       RD1E,
    input  logic [XLEN-1:0]       RD2E,
    input  logic [XLEN-1:0]       ExtImmE,
    input  logic [XLEN-1:0]       ResultW,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    output logic                  BusyE,
    output logic                  ValidM,
    output logic                  RegWriteM,
    output logic                  ResultSrcM,
    output logic                  MemWriteM,
    output logic [MEM_TYPE_W-1:0] MemTypeM,
    output logic [XLEN-1:0]       ALUResultM,
    output logic [XLEN-1:0]       WriteDataM,
    output logic [REG_ADDR_W-1:0] RdM
);
    localparam int SHW   = $clog2(XLEN);
    localparam int CNT_W = SHW + 1;

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND    = 5'd2,  OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL    = 5'd6,  OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_PASSB  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
    localparam logic [4:0] OP_DIV  = 5'd20, OP_DIVU = 5'd21, OP_REM    = 5'd22, OP_REMU  = 5'd23;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [XLEN-1:0]       r_quo;
    logic [XLEN-1:0]       r_rem;
    logic [XLEN-1:0]       r_dvs;
    logic [XLEN-1:0]       r_dvd;
    logic                  r_neg_a, r_neg_b, r_is_rem, r_dvs_zero;
    logic                  r_sh_regwrite, r_sh_resultsrc, r_sh_memwrite;
    logic [MEM_TYPE_W-1:0] r_sh_memtype;
    logic [REG_ADDR_W-1:0] r_sh_rd;
    logic [XLEN-1:0]       r_sh_wdata;

    logic [XLEN-1:0]   w_src_a, w_fwd_b, w_src_b, w_alu_res, w_fast_res, w_exec_res;
    logic [SHW-1:0]    w_shamt;
    logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_mul_p;
    logic              w_mul_sa, w_mul_sb;
    logic              w_div_op, w_div_signed, w_div_rem, w_neg_a, w_neg_b, w_fast, w_issue;
    logic [XLEN-1:0]   w_mag_a, w_mag_b;
    logic [XLEN:0]     w_rem_sh, w_rem_diff;

    // Final divide result from unsigned magnitudes, including the x/0 rule.
    function automatic logic [XLEN-1:0] div_result(
        input logic is_rem, input logic neg_a, input logic neg_b, input logic dvs_zero,
        input logic [XLEN-1:0] q_mag, input logic [XLEN-1:0] r_mag, input logic [XLEN-1:0] dvd);
        if (dvs_zero) return is_rem ? dvd : '1;
        if (is_rem)   return neg_a ? -r_mag : r_mag;
        return (neg_a ^ neg_b) ? -q_mag : q_mag;
    endfunction

    // Forwarding muxes and SrcB immediate select.
    always_comb begin
        case (ForwardAE)
            2'b01:   w_src_a = ResultW;
            2'b10:   w_src_a = ALUResultM;
            default: w_src_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   w_fwd_b = ResultW;
            2'b10:   w_fwd_b = ALUResultM;
            default: w_fwd_b = RD2E;
        endcase
        w_src_b = ALUSrcE ? ExtImmE : w_fwd_b;
    end

    // One shared 2*XLEN multiplier; operands are sign- or zero-extended per op.
    assign w_mul_sa = (ALUCtrlE == OP_MULH) || (ALUCtrlE == OP_MULHSU);
    assign w_mul_sb = (ALUCtrlE == OP_MULH);
    assign w_mul_a  = {{XLEN{w_mul_sa & w_src_a[XLEN-1]}}, w_src_a};
    assign w_mul_b  = {{XLEN{w_mul_sb & w_src_b[XLEN-1]}}, w_src_b};
    assign w_mul_p  = w_mul_a * w_mul_b;
    assign w_shamt  = w_src_b[SHW-1:0];

    // Single-cycle ALU result.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_alu_res = '0;
        case (ALUCtrlE)
            OP_ADD:    w_alu_res = w_src_a + w_src_b;
            OP_SUB:    w_alu_res = w_src_a - w_src_b;
            OP_AND:    w_alu_res = w_src_a & w_src_b;
            OP_OR:     w_alu_res = w_src_a | w_src_b;
            OP_XOR:    w_alu_res = w_src_a ^ w_src_b;
            OP_SLL:    w_alu_res = w_src_a << w_shamt;
            OP_SRL:    w_alu_res = w_src_a >> w_shamt;
            OP_SRA:    w_alu_res = $signed(w_src_a) >>> w_shamt;
            OP_SLT:    w_alu_res = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
            OP_SLTU:   w_alu_res = {{(XLEN-1){1'b0}}, w_src_a < w_src_b};
            OP_PASSB:  w_alu_res = w_src_b;
            OP_MUL:    w_alu_res = w_mul_p[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_alu_res = w_mul_p[2*XLEN-1:XLEN];
            default:   w_alu_res = '0;
        endcase
    end

    // Divide decode and operand magnitudes.
    assign w_div_op     = (ALUCtrlE >= OP_DIV) && (ALUCtrlE <= OP_REMU);
    assign w_div_signed = (ALUCtrlE == OP_DIV) || (ALUCtrlE == OP_REM);
    assign w_div_rem    = (ALUCtrlE == OP_REM) || (ALUCtrlE == OP_REMU);
    assign w_neg_a      = w_div_signed & w_src_a[XLEN-1];
    assign w_neg_b      = w_div_signed & w_src_b[XLEN-1];
    assign w_mag_a      = w_neg_a ? -w_src_a : w_src_a;
    assign w_mag_b      = w_neg_b ? -w_src_b : w_src_b;

`ifdef EXEC_DIV_FASTPATH_EN
    assign w_fast     = w_div_op && (w_mag_b[XLEN-1:1] == '0);
    assign w_fast_res = div_result(w_div_rem, w_neg_a, w_neg_b, w_mag_b[0] == 1'b0,
                                   w_mag_a, '0, w_src_a);
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    assign w_exec_res = w_fast ? w_fast_res : w_alu_res;
    assign w_issue    = ValidE & w_div_op & ~FlushE & ~w_fast;

    // Busy covers the issue cycle and every iteration; forced low in reset.
    assign BusyE = rst_n & (((r_state == S_IDLE) & w_issue) | (r_state == S_DIV));

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_dvs};

    // Divide FSM, divider datapath and the E->M register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_quo          <= '0;
            r_rem          <= '0;
            r_dvs          <= '0;
            r_dvd          <= '0;
            r_neg_a        <= 1'b0;
            r_neg_b        <= 1'b0;
            r_is_rem       <= 1'b0;
            r_dvs_zero     <= 1'b0;
            r_sh_regwrite  <= 1'b0;
            r_sh_resultsrc <= 1'b0;
            r_sh_memwrite  <= 1'b0;
            r_sh_memtype   <= '0;
            r_sh_rd        <= '0;
            r_sh_wdata     <= '0;
            ValidM         <= 1'b0;
            RegWriteM      <= 1'b0;
            ResultSrcM     <= 1'b0;
            MemWriteM      <= 1'b0;
            MemTypeM       <= '0;
            ALUResultM     <= '0;
            WriteDataM     <= '0;
            RdM            <= '0;
        end else begin
            // NOTE: non-blocking defaults load a bubble; later assignments in this block win.
            ValidM     <= 1'b0;
            RegWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            MemWriteM  <= 1'b0;
            MemTypeM   <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            RdM        <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state        <= S_DIV;
                        r_cnt          <= CNT_W'(XLEN);
                        r_quo          <= w_mag_a;
                        r_rem          <= '0;
                        r_dvs          <= w_mag_b;
                        r_dvd          <= w_src_a;
                        r_neg_a        <= w_neg_a;
                        r_neg_b        <= w_neg_b;
                        r_is_rem       <= w_div_rem;
                        r_dvs_zero     <= (w_mag_b == '0);
                        r_sh_regwrite  <= RegWriteE;
                        r_sh_resultsrc <= ResultSrcE;
                        r_sh_memwrite  <= MemWriteE;
                        r_sh_memtype   <= MemTypeE;
                        r_sh_rd        <= RdE;
                        r_sh_wdata     <= w_fwd_b;
                    end else if (!FlushE) begin
                        ValidM     <= ValidE;
                        RegWriteM  <= RegWriteE & ValidE;
                        MemWriteM  <= MemWriteE & ValidE;
                        ResultSrcM <= ResultSrcE;
                        MemTypeM   <= MemTypeE;
                        ALUResultM <= w_exec_res;
                        WriteDataM <= w_fwd_b;
                        RdM        <= RdE;
                    end
                end
                S_DIV: begin
                    if (FlushE) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (!w_rem_diff[XLEN]) begin
                            r_rem <= w_rem_diff[XLEN-1:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b1};
                        end else begin
                            r_rem <= w_rem_sh[XLEN-1:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (!FlushE) begin
                        ValidM     <= 1'b1;
                        RegWriteM  <= r_sh_regwrite;
                        ResultSrcM <= r_sh_resultsrc;
                        MemWriteM  <= r_sh_memwrite;
                        MemTypeM   <= r_sh_memtype;
                        ALUResultM <= div_result(r_is_rem, r_neg_a, r_neg_b, r_dvs_zero,
                                                 r_quo, r_rem, r_dvd);
                        WriteDataM <= r_sh_wdata;
                        RdM        <= r_sh_rd;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_execute_stage_md.sv
// tb_execute_stage_md: directed vector table for single-cycle ops plus
// hand-written divide, flush and reset sequences (XLEN=32).
module tb_execute_stage_md;
    localparam int XLEN = 32;
`ifdef EXEC_DIV_FASTPATH_EN
    localparam int FAST_BUSY = 0;
`else
    localparam int FAST_BUSY = XLEN + 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ValidE, FlushE, RegWriteE, ResultSrcE, MemWriteE, ALUSrcE;
    logic [0:0]      MemTypeE;
    logic [4:0]      ALUCtrlE, RdE;
    logic [XLEN-1:0] RD1E, RD2E, ExtImmE, ResultW;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            BusyE, ValidM, RegWriteM, ResultSrcM, MemWriteM;
    logic [0:0]      MemTypeM;
    logic [XLEN-1:0] ALUResultM, WriteDataM;
    logic [4:0]      RdM;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    execute_stage_md #(.XLEN(XLEN), .REG_ADDR_W(5), .MEM_TYPE_W(1)) dut (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .MemTypeE(MemTypeE), .ALUCtrlE(ALUCtrlE), .ALUSrcE(ALUSrcE),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .ResultW(ResultW), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .BusyE(BusyE),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .MemTypeM(MemTypeM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .RdM(RdM)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string           name;
        logic [4:0]      ctrl;
        logic [1:0]      fa, fb;
        logic            alusrc, flush, memw;
        logic [XLEN-1:0] rd1, rd2, imm, resw;
        logic [XLEN-1:0] exp_res, exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [4:0] ctrl,
                                input logic [1:0] fa, input logic [1:0] fb, input logic alusrc,
                                input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
                                input logic [XLEN-1:0] imm, input logic [XLEN-1:0] resw,
                                input logic flush, input logic memw,
                                input logic [XLEN-1:0] exp_res, input logic [XLEN-1:0] exp_wdata);
        vec_t v;
        v.name = name; v.ctrl = ctrl; v.fa = fa; v.fb = fb; v.alusrc = alusrc;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw; v.flush = flush; v.memw = memw;
        v.exp_res = exp_res; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic drive_idle();
        ValidE = 0; FlushE = 0; RegWriteE = 0; ResultSrcE = 0; MemWriteE = 0; MemTypeE = 0;
        ALUCtrlE = 0; ALUSrcE = 0; RD1E = 0; RD2E = 0; ExtImmE = 0; ResultW = 0; RdE = 0;
        ForwardAE = 0; ForwardBE = 0;
    endtask

    task automatic drive_op(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        ValidE = 1; FlushE = 0; RegWriteE = 1; ResultSrcE = 1; MemWriteE = 0; MemTypeE = 0;
        ALUCtrlE = op; ALUSrcE = 0; RD1E = a; RD2E = b; ExtImmE = 0; ResultW = 0; RdE = 5'd9;
        ForwardAE = 0; ForwardBE = 0;
    endtask

    // Issue a divide, count busy cycles, confirm bubbles, then check the result.
    task automatic run_div(input string name, input logic [4:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res, input int exp_busy);
        int busy = 0;
        bit saw_valid = 0;
        @(negedge clk);
        drive_op(op, a, b);
        #1;
        while (BusyE && busy < 100) begin
            busy++;
            @(posedge clk); #1;
            if (ValidM) saw_valid = 1;
        end
        check({name, ":busy_cycles"}, 64'(busy), 64'(exp_busy));
        check({name, ":bubbles"}, 64'(saw_valid), 64'd0);
        @(posedge clk); #1;
        check({name, ":result"}, ALUResultM, exp_res);
        check({name, ":valid"}, ValidM, 1'b1);
        check({name, ":rd"}, RdM, 5'd9);
        check({name, ":wdata"}, WriteDataM, b);
        ValidE = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_valid;

        // ---------------- vector table ----------------
        //           name     ctrl   fa    fb    isrc rd1           rd2           imm          resw   fl mw exp_res       exp_wdata
        vecs.push_back(mk("add",    5'd0,  2'd0, 2'd0, 0, 32'd2,        32'd3,        32'd0,       32'd0, 0, 0, 32'd5,        32'd3));
        vecs.push_back(mk("add_fwdM",5'd0, 2'd2, 2'd0, 0, 32'd99,       32'd7,        32'd0,       32'd0, 0, 0, 32'd12,       32'd7));
        vecs.push_back(mk("sub",    5'd1,  2'd0, 2'd0, 0, 32'd5,        32'd7,        32'd0,       32'd0, 0, 0, 32'hFFFFFFFE, 32'd7));
        vecs.push_back(mk("and_imm",5'd2,  2'd0, 2'd0, 1, 32'h1234,     32'hAAAA,     32'h0F0F,    32'd0, 0, 0, 32'h0204,     32'hAAAA));
        vecs.push_back(mk("or",     5'd3,  2'd0, 2'd0, 0, 32'h1200,     32'h0034,     32'd0,       32'd0, 0, 0, 32'h1234,     32'h0034));
        vecs.push_back(mk("xor",    5'd4,  2'd0, 2'd0, 0, 32'hFFFF0000, 32'hFF00FF00, 32'd0,       32'd0, 0, 0, 32'h00FFFF00, 32'hFF00FF00));
        vecs.push_back(mk("sll",    5'd5,  2'd0, 2'd0, 1, 32'd1,        32'd0,        32'h23,      32'd0, 0, 0, 32'd8,        32'd0));
        vecs.push_back(mk("srl",    5'd6,  2'd0, 2'd0, 0, 32'h80000000, 32'd4,        32'd0,       32'd0, 0, 0, 32'h08000000, 32'd4));
        vecs.push_back(mk("sra",    5'd7,  2'd0, 2'd0, 0, 32'h80000000, 32'd4,        32'd0,       32'd0, 0, 0, 32'hF8000000, 32'd4));
        vecs.push_back(mk("slt",    5'd8,  2'd0, 2'd0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,       32'd0, 0, 0, 32'd1,        32'd1));
        vecs.push_back(mk("sltu",   5'd9,  2'd0, 2'd0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,       32'd0, 0, 0, 32'd0,        32'd1));
        vecs.push_back(mk("passb",  5'd10, 2'd0, 2'd0, 1, 32'd0,        32'h11,       32'hCAFE,    32'd0, 0, 0, 32'hCAFE,     32'h11));
        vecs.push_back(mk("mul",    5'd16, 2'd0, 2'd0, 0, 32'hFFFFFFFF, 32'd3,        32'd0,       32'd0, 0, 0, 32'hFFFFFFFD, 32'd3));
        vecs.push_back(mk("mulh",   5'd17, 2'd0, 2'd0, 0, 32'h80000000, 32'd2,        32'd0,       32'd0, 0, 0, 32'hFFFFFFFF, 32'd2));
        vecs.push_back(mk("mulhu",  5'd19, 2'd0, 2'd0, 0, 32'h80000000, 32'd2,        32'd0,       32'd0, 0, 0, 32'h00000001, 32'd2));
        vecs.push_back(mk("mulhsu", 5'd18, 2'd0, 2'd0, 0, 32'h80000000, 32'hFFFFFFFF, 32'd0,       32'd0, 0, 0, 32'h80000000, 32'hFFFFFFFF));
        vecs.push_back(mk("undef",  5'd11, 2'd0, 2'd0, 0, 32'd5,        32'd6,        32'd0,       32'd0, 0, 0, 32'd0,        32'd6));
        vecs.push_back(mk("fwdB_W", 5'd0,  2'd0, 2'd1, 0, 32'd1,        32'h99,       32'd0,       32'h55,0, 1, 32'h56,       32'h55));
        vecs.push_back(mk("fwdA11", 5'd0,  2'd3, 2'd2, 0, 32'h10,       32'h99,       32'd0,       32'h55,0, 0, 32'h66,       32'h56));
        vecs.push_back(mk("flush",  5'd0,  2'd0, 2'd0, 0, 32'd1,        32'd2,        32'd0,       32'd0, 1, 1, 32'd0,        32'd0));

        // ---------------- reset state ----------------
        drive_idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        ValidE = 1; ALUCtrlE = 5'd20; RD1E = 32'd7; RD2E = 32'd2;
        #3;
        check("rst:busy", BusyE, 1'b0);
        check("rst:valid", ValidM, 1'b0);
        check("rst:regwrite", RegWriteM, 1'b0);
        check("rst:memwrite", MemWriteM, 1'b0);
        check("rst:resultsrc", ResultSrcM, 1'b0);
        check("rst:memtype", MemTypeM, 1'b0);
        check("rst:result", ALUResultM, 32'd0);
        check("rst:wdata", WriteDataM, 32'd0);
        check("rst:rd", RdM, 5'd0);
        drive_idle();
        @(negedge clk); rst_n = 1'b1;

        // ---------------- single-cycle table ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            ValidE = 1; FlushE = vecs[i].flush; RegWriteE = 1; ResultSrcE = 1;
            MemWriteE = vecs[i].memw; MemTypeE = 1; ALUCtrlE = vecs[i].ctrl;
            ALUSrcE = vecs[i].alusrc; RD1E = vecs[i].rd1; RD2E = vecs[i].rd2;
            ExtImmE = vecs[i].imm; ResultW = vecs[i].resw; RdE = 5'(i + 1);
            ForwardAE = vecs[i].fa; ForwardBE = vecs[i].fb;
            #1;
            check({vecs[i].name, ":busy"}, BusyE, 1'b0);
            @(posedge clk); #1;
            check({vecs[i].name, ":result"}, ALUResultM, vecs[i].exp_res);
            check({vecs[i].name, ":wdata"}, WriteDataM, vecs[i].exp_wdata);
            check({vecs[i].name, ":valid"}, ValidM, !vecs[i].flush);
            check({vecs[i].name, ":regwrite"}, RegWriteM, !vecs[i].flush);
            check({vecs[i].name, ":memwrite"}, MemWriteM, vecs[i].memw & !vecs[i].flush);
            check({vecs[i].name, ":resultsrc"}, ResultSrcM, !vecs[i].flush);
            check({vecs[i].name, ":memtype"}, MemTypeM, !vecs[i].flush);
            check({vecs[i].name, ":rd"}, RdM, vecs[i].flush ? 5'd0 : 5'(i + 1));
        end
        @(negedge clk); drive_idle();

        // ---------------- divides ----------------
        run_div("div_m7_2",   5'd20, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, XLEN + 1);
        run_div("rem_m7_2",   5'd22, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, XLEN + 1);
        run_div("divu_9_0",   5'd21, 32'd9,        32'd0,        32'hFFFFFFFF, FAST_BUSY);
        run_div("rem_m9_0",   5'd22, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, FAST_BUSY);
        run_div("div_min_m1", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, FAST_BUSY);
        run_div("rem_min_m1", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0,        FAST_BUSY);
        run_div("div_100_m7", 5'd20, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, XLEN + 1);
        run_div("remu_100_7", 5'd23, 32'd100,      32'd7,        32'd2,        XLEN + 1);

        // ---------------- flush mid-divide ----------------
        @(negedge clk); drive_op(5'd20, 32'd100, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk); FlushE = 1;
        @(posedge clk); #1;
        check("flush:valid", ValidM, 1'b0);
        check("flush:regwrite", RegWriteM, 1'b0);
        drive_idle(); #1;
        check("flush:busy_after", BusyE, 1'b0);
        @(negedge clk); drive_op(5'd0, 32'd20, 32'd22);
        @(posedge clk); #1;
        check("flush:add_result", ALUResultM, 32'd42);
        check("flush:add_valid", ValidM, 1'b1);
        drive_idle();
        saw_valid = 0;
        repeat (40) begin @(posedge clk); #1; if (ValidM) saw_valid = 1; end
        check("flush:no_late_result", 64'(saw_valid), 64'd0);

        // ---------------- reset mid-divide ----------------
        @(negedge clk); drive_op(5'd21, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("rstdiv:busy", BusyE, 1'b0);
        check("rstdiv:valid", ValidM, 1'b0);
        check("rstdiv:result", ALUResultM, 32'd0);
        check("rstdiv:rd", RdM, 5'd0);
        @(negedge clk); drive_idle(); rst_n = 1'b1;
        saw_valid = 0;
        repeat (40) begin @(posedge clk); #1; if (ValidM || BusyE) saw_valid = 1; end
        check("rstdiv:no_result", 64'(saw_valid), 64'd0);
        run_div("divu_100_7", 5'd21, 32'd100, 32'd7, 32'd14, XLEN + 1);

        @(negedge clk); drive_idle();
        @(posedge clk); #1;
        check("final:idle_valid", ValidM, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
- Parametrised RV32IM/RV64IM execute stage: forwarding muxes, single-cycle ALU and multiplier, iterative restoring divider, and the E->M pipeline register.
- Sits between the decode/E-register and the memory stage.
- Adds a valid/flush/busy handshake so multi-cycle divides can stall the front end while the back end drains.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- REG_ADDR_W, 5, register index width.
- MEM_TYPE_W, 1, width of the memory access-type field passed through.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ValidE  in  1  E inputs hold a real instruction.
- FlushE  in  1  kill the instruction in E, including any divide in flight.
- RegWriteE, ResultSrcE, MemWriteE  in  1 each  control bits, piped to M.
- MemTypeE  in  MEM_TYPE_W  memory type, piped to M.
- ALUCtrlE  in  5  operation select.
- ALUSrcE  in  1  1: SrcB=ExtImmE.
- RD1E, RD2E, ExtImmE, ResultW  in  XLEN  operand sources.
- RdE  in  REG_ADDR_W  destination register.
- ForwardAE, ForwardBE  in  2  00 RDx, 01 ResultW, 10 ALUResultM, 11 RDx.
- BusyE  out  1  E occupied; upstream must hold E inputs and the hazard unit must stall.
- ValidM, RegWriteM, ResultSrcM, MemWriteM  out  1  registered.
- MemTypeM  out  MEM_TYPE_W  registered.
- ALUResultM, WriteDataM  out  XLEN  registered.
- RdM  out  REG_ADDR_W  registered.

Behaviour:
- Reset (async on rst_n low): all M outputs 0, FSM IDLE, divider registers 0. BusyE=0 while in reset.
- Operand path:
  - SrcA = forwarded RD1E.
  - FwdB = forwarded RD2E; SrcB = ALUSrcE ? ExtImmE : FwdB.
  - WriteDataM captures FwdB.
- ALUCtrlE codes (single-cycle, result registered on the next edge):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is SrcB[log2(XLEN)-1:0].
  - 8 SLT, 9 SLTU, 10 PASSB.
  - 16 MUL (low XLEN), 17 MULH, 18 MULHSU, 19 MULHU (upper XLEN of the 2*XLEN product).
  - Undefined codes produce 0.
- Divide codes: 20 DIV, 21 DIVU, 22 REM, 23 REMU. These use the FSM.
- FSM:
  - IDLE:
    - ValidE & div op & !FlushE: BusyE=1 combinationally. On the edge, capture operand magnitudes, signs, op and all control/Rd into shadow registers. Load counter=XLEN. Go DIV. M register loads a bubble.
    - Otherwise: normal single-cycle op; M loads E values with ValidM=ValidE&!FlushE.
  - DIV: BusyE=1. One restoring step per cycle; counter decrements. When counter reaches 1, go DONE on that edge. M register holds bubbles throughout.
  - DONE: BusyE=0. Apply sign correction:
    - Quotient negated if operand signs differ (signed ops only).
    - Remainder takes the dividend's sign.
    - The result and shadow controls load into M on this edge. Go IDLE.
  - Total latency: divide issued in cycle t writes M at the end of cycle t+XLEN+1. BusyE is high for XLEN+1 cycles.
- Operands are captured in IDLE because ForwardAE/BE sources change while M drains. Inputs are ignored in DIV and DONE.
- Divide by zero: quotient = all ones, remainder = original dividend. Sign correction is skipped.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- FlushE:
  - In IDLE: M loads a bubble (ValidM, RegWriteM, MemWriteM = 0).
  - In DIV or DONE: abort, go IDLE, M loads a bubble. BusyE=0 the following cycle.
- A bubble forces ValidM=RegWriteM=MemWriteM=0. Data fields are don't-care but are driven to 0.
- Reset mid-divide: immediate IDLE; no result is produced.

Optional Feature:
- Macro: EXEC_DIV_FASTPATH_EN.
- Defined: in IDLE, divisor==0 or divisor==1 (unsigned magnitude) resolves in a single cycle like ALU ops. BusyE stays 0 and results follow the same rules above.
- Undefined: every divide takes the full XLEN+2-cycle path.

Test Plan:
- ADD, ForwardAE=10, ALUResultM=5, RD2E=7, ALUSrcE=0 -> next edge ALUResultM=12, ValidM=1.
- MULH, SrcA=0x80000000, SrcB=2 -> ALUResultM=0xFFFFFFFF. MULHU with the same operands -> 0x00000001.
- DIV, -7/2 (XLEN=32) -> BusyE high 33 cycles, bubbles in M, then ALUResultM=0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF.
- DIVU 9/0 -> 0xFFFFFFFF. REM -9/0 -> 0xFFFFFFF7. DIV 0x80000000/-1 -> 0x80000000. With EXEC_DIV_FASTPATH_EN, all three complete with BusyE=0.
- FlushE asserted 10 cycles into a DIV -> next cycle BusyE=0 and ValidM=0. A following ADD completes normally.
- rst_n low mid-divide -> all M outputs 0 and BusyE=0 immediately. After release, a new DIVU 100/7 gives 14 after 33 busy cycles.
